// File: rtl/instr_mem_loader_pkg.sv
// instr_mem_loader_pkg
//   Types and constants shared by the instruction-memory loader.
//   The CHECK state exists only when LOADER_CHECKSUM_EN is defined.
package instr_mem_loader_pkg;

  localparam logic [63:0] DEFAULT_BASE_ADDR = 64'h0000_0000_0004_0000;
  localparam int unsigned DEFAULT_MEM_DEPTH = 101;
  localparam int unsigned BYTES_PER_WORD    = 4;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    WRITE
`ifdef LOADER_CHECKSUM_EN
    , CHECK
`endif
  } state_t;

endpackage

// File: rtl/instr_mem_loader_byte_packer.sv
// byte_packer
//   Assembles big-endian bytes into 32-bit words.
//   clk, rst     : clock, synchronous active-high reset
//   clr          : clears the shift register and byte counter
//   shift_en     : accept byte_in this cycle
//   byte_in      : incoming byte
//   word_next    : word including the byte being accepted now
//   word_done    : the byte accepted now completes a word
module byte_packer
  import instr_mem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        shift_en,
  input  logic [7:0]  byte_in,
  output logic [31:0] word_next,
  output logic        word_done
);

  logic [31:0] shreg;
  logic [1:0]  cnt;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      shreg <= '0;
      cnt   <= '0;
    end else if (shift_en) begin
      shreg <= {shreg[23:0], byte_in};
      cnt   <= cnt + 2'd1;  // wraps to 0 after the last byte of a word
    end
  end

  // Exposing the word as it will look after this byte lets the top capture
  // it on the handshake edge, giving a one-cycle write latency.
  assign word_next = {shreg[23:0], byte_in};
  assign word_done = shift_en && (cnt == 2'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/instr_mem_loader.sv
// instr_mem_loader
//   Loads a big-endian byte stream into instruction memory, one 32-bit word
//   per line starting at BASE_ADDR.
//   Optional macro LOADER_CHECKSUM_EN: a 4-byte trailer word follows the
//   data and is compared with the XOR of all loaded words.
// Ports:
//   clk, rst              : clock, synchronous active-high reset
//   start, word_count     : begin a session of word_count words
//   in_valid, in_byte     : byte stream input
//   in_ready              : byte accepted when in_valid && in_ready
//   mem_we                : write strobe
//   mem_line, mem_pc      : word index and byte address being written
//   mem_data              : word being written
//   busy, done, err       : session status, done / error pulses
module instr_mem_loader
  import instr_mem_loader_pkg::*;
#(
  parameter logic [63:0] BASE_ADDR = DEFAULT_BASE_ADDR,
  parameter int unsigned MEM_DEPTH = DEFAULT_MEM_DEPTH
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  word_count,
  input  logic        in_valid,
  input  logic [7:0]  in_byte,
  output logic        in_ready,
  output logic        mem_we,
  output logic [63:0] mem_line,
  output logic [63:0] mem_pc,
  output logic [31:0] mem_data,
  output logic        busy,
  output logic        done,
  output logic        err
);

  state_t      state, state_nxt;
  logic [7:0]  wc_q;
  logic [7:0]  line_q;
  logic        start_ok;
  logic        last_line;
  logic        shift_en;
  logic        pack_clr;
  logic        session_end;
  logic        err_nxt;
  logic [31:0] word_next;
  logic        word_done;
`ifdef LOADER_CHECKSUM_EN
  logic [31:0] xor_acc;
`endif

  byte_packer u_packer (
    .clk      (clk),
    .rst      (rst),
    .clr      (pack_clr),
    .shift_en (shift_en),
    .byte_in  (in_byte),
    .word_next(word_next),
    .word_done(word_done)
  );

  assign start_ok  = (word_count != 8'd0) && ({24'b0, word_count} <= MEM_DEPTH);
  assign last_line = (line_q + 8'd1) == wc_q;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    in_ready    = 1'b0;
    busy        = 1'b1;
    mem_we      = 1'b0;
    shift_en    = 1'b0;
    pack_clr    = 1'b0;
    session_end = 1'b0;
    err_nxt     = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          if (start_ok) begin
            state_nxt = LOAD;
            pack_clr  = 1'b1;
          end else begin
            err_nxt = 1'b1;
          end
        end
      end
      LOAD: begin
        in_ready = 1'b1;
        shift_en = in_valid;
        if (word_done) state_nxt = WRITE;
      end
      WRITE: begin
        mem_we = 1'b1;
        if (last_line) begin
`ifdef LOADER_CHECKSUM_EN
          state_nxt = CHECK;
`else
          state_nxt   = IDLE;
          session_end = 1'b1;
`endif
        end else begin
          state_nxt = LOAD;
        end
      end
`ifdef LOADER_CHECKSUM_EN
      CHECK: begin
        in_ready = 1'b1;
        shift_en = in_valid;
        if (word_done) begin
          state_nxt   = IDLE;
          session_end = 1'b1;
          err_nxt     = (word_next != xor_acc);
        end
      end
`endif
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wc_q     <= '0;
      line_q   <= '0;
      mem_line <= '0;
      mem_pc   <= BASE_ADDR;
      mem_data <= '0;
      done     <= 1'b0;
      err      <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      xor_acc  <= '0;
`endif
    end else begin
      done <= session_end;
      err  <= err_nxt;
      if (state == IDLE && start && start_ok) begin
        wc_q    <= word_count;
        line_q  <= '0;
`ifdef LOADER_CHECKSUM_EN
        xor_acc <= '0;
`endif
      end
      // Output registers are loaded on the last-byte edge so they are valid
      // throughout the single WRITE cycle and hold afterwards.
      if (state == LOAD && word_done) begin
        mem_data <= word_next;
        mem_line <= {56'b0, line_q};
        mem_pc   <= BASE_ADDR + {54'b0, line_q, 2'b00};
      end
      if (state == WRITE) begin
        line_q  <= line_q + 8'd1;
`ifdef LOADER_CHECKSUM_EN
        xor_acc <= xor_acc ^ mem_data;
`endif
      end
    end
  end

endmodule

// File: tb/tb_instr_mem_loader.sv
module tb_instr_mem_loader;

  localparam logic [63:0] BASE = 64'h0000_0000_0004_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  word_count = '0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_byte = '0;
  logic        in_ready, mem_we, busy, done, err;
  logic [63:0] mem_line, mem_pc;
  logic [31:0] mem_data;

  always #5 clk = ~clk;

  instr_mem_loader #(.BASE_ADDR(BASE), .MEM_DEPTH(101)) dut (
    .clk(clk), .rst(rst), .start(start), .word_count(word_count),
    .in_valid(in_valid), .in_byte(in_byte), .in_ready(in_ready),
    .mem_we(mem_we), .mem_line(mem_line), .mem_pc(mem_pc),
    .mem_data(mem_data), .busy(busy), .done(done), .err(err)
  );

  typedef struct packed {
    logic [63:0] line;
    logic [63:0] pc;
    logic [31:0] data;
  } wr_t;

  wr_t         exp_wr[$];
  logic [1:0]  exp_ev[$];   // {done, err}
  logic [31:0] sess_words[$];
  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: every write and every done/err pulse must match the
  // next expected entry.
  always @(negedge clk) begin
    if (!rst) begin
      if (mem_we) begin
        if (exp_wr.size() == 0) check("unexpected_write", {63'b0, mem_we}, 64'd0);
        else begin
          wr_t w;
          w = exp_wr.pop_front();
          check("wr_line", mem_line, w.line);
          check("wr_pc", mem_pc, w.pc);
          check("wr_data", {32'b0, mem_data}, {32'b0, w.data});
        end
      end
      if (done || err) begin
        if (exp_ev.size() == 0) check("unexpected_done_err", {62'b0, done, err}, 64'd0);
        else begin
          logic [1:0] e;
          e = exp_ev.pop_front();
          check("done_err", {62'b0, done, err}, {62'b0, e});
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [7:0] wc);
    start = 1'b1;
    word_count = wc;
    tick();
    start = 1'b0;
    word_count = 8'($urandom);
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    in_valid = 1'b0;
    repeat (gap) tick();
    in_valid = 1'b1;
    in_byte  = b;
    n = 0;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    if (!in_ready) check("in_ready_timeout", {63'b0, in_ready}, 64'd1);
    tick();
    in_valid = 1'b0;
    in_byte  = 8'($urandom);
  endtask

  function automatic int gap_for(input int mode);
    if (mode == 0) return 0;
    if (mode == 1) return 1;
    return int'($urandom_range(0, 2));
  endfunction

  task automatic send_word(input logic [31:0] w, input int gap_mode);
    for (int b = 0; b < 4; b++)
      send_byte(8'(w >> (24 - 8 * b)), gap_for(gap_mode));
  endtask

  // One full session over sess_words. bad_trailer selects a corrupted
  // checksum trailer when the checksum build is in use.
  task automatic run_session(input int gap_mode, input bit inject, input bit bad_trailer);
    int          wc;
    logic [31:0] xr;
    logic [31:0] tr;
    wc = sess_words.size();
    xr = '0;
    for (int i = 0; i < wc; i++) begin
      exp_wr.push_back('{64'(i), BASE + 64'(i) * 64'd4, sess_words[i]});
      xr ^= sess_words[i];
    end
    tr = bad_trailer ? ~xr : xr;
`ifdef LOADER_CHECKSUM_EN
    exp_ev.push_back({1'b1, tr != xr});
`else
    exp_ev.push_back(2'b10);
`endif
    do_start(8'(wc));
    check("busy_after_start", {63'b0, busy}, 64'd1);
    for (int i = 0; i < wc; i++) begin
      for (int b = 0; b < 4; b++) begin
        if (inject && i == 0 && b == 1) begin
          start = 1'b1;
          word_count = 8'(wc + 3);
          tick();
          start = 1'b0;
        end
        send_byte(8'(sess_words[i] >> (24 - 8 * b)), gap_for(gap_mode));
      end
      check("write_latency", {63'b0, mem_we}, 64'd1);
    end
`ifdef LOADER_CHECKSUM_EN
    send_word(tr, gap_mode);
`else
    tick();
`endif
    check("done_timing", {63'b0, done}, 64'd1);
    check("busy_at_done", {63'b0, busy}, 64'd0);
    tick();
    check("done_one_cycle", {63'b0, done}, 64'd0);
  endtask

  task automatic bad_start(input logic [7:0] wc);
    exp_ev.push_back(2'b01);
    do_start(wc);
    check("bad_start_err", {63'b0, err}, 64'd1);
    check("bad_start_busy", {63'b0, busy}, 64'd0);
    tick();
    check("bad_start_err_clear", {63'b0, err}, 64'd0);
    check("bad_start_idle", {63'b0, busy}, 64'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"}, {63'b0, in_ready}, 64'd0);
    check({tag, "_mem_we"}, {63'b0, mem_we}, 64'd0);
    check({tag, "_mem_line"}, mem_line, 64'd0);
    check({tag, "_mem_pc"}, mem_pc, BASE);
    check({tag, "_mem_data"}, {32'b0, mem_data}, 64'd0);
    check({tag, "_busy"}, {63'b0, busy}, 64'd0);
    check({tag, "_done"}, {63'b0, done}, 64'd0);
    check({tag, "_err"}, {63'b0, err}, 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) tick();
    check_reset_outputs("reset");
    rst = 1'b0;
    tick();

    // Reference two-word program
    sess_words = '{32'h7C0802A6, 32'h38600005};
    run_session(0, 1'b0, 1'b0);

    bad_start(8'd0);
    bad_start(8'd102);
    bad_start(8'd255);

    // Stalling in_valid every other cycle
    sess_words = '{32'($urandom)};
    run_session(1, 1'b0, 1'b0);

    // start while busy is ignored
    sess_words = '{32'($urandom), 32'($urandom)};
    run_session(2, 1'b1, 1'b0);

    for (int s = 0; s < 6; s++) begin
      int n;
      n = int'($urandom_range(1, 5));
      sess_words.delete();
      for (int i = 0; i < n; i++) sess_words.push_back(32'($urandom));
      run_session(2, 1'b0, 1'($urandom_range(0, 1)));
    end

    // Largest legal session: last line is MEM_DEPTH-1
    sess_words.delete();
    for (int i = 0; i < 101; i++) sess_words.push_back(32'($urandom));
    run_session(0, 1'b0, 1'b0);

`ifdef LOADER_CHECKSUM_EN
    sess_words = '{32'h00000001, 32'h00000003};
    exp_wr.push_back('{64'd0, BASE, 32'h00000001});
    exp_wr.push_back('{64'd1, BASE + 64'd4, 32'h00000003});
    exp_ev.push_back(2'b10);
    do_start(8'd2);
    send_word(32'h00000001, 0);
    send_word(32'h00000003, 0);
    send_word(32'h00000002, 0);
    check("chk_good_done", {62'b0, done, err}, 64'd2);
    tick();
    exp_wr.push_back('{64'd0, BASE, 32'h00000001});
    exp_wr.push_back('{64'd1, BASE + 64'd4, 32'h00000003});
    exp_ev.push_back(2'b11);
    do_start(8'd2);
    send_word(32'h00000001, 0);
    send_word(32'h00000003, 0);
    send_word(32'h00000000, 0);
    check("chk_bad_done_err", {62'b0, done, err}, 64'd3);
    tick();
`endif

    // Reset after 6 bytes of a 3-word load: only line 0 is written
    sess_words = '{32'($urandom), 32'($urandom), 32'($urandom)};
    exp_wr.push_back('{64'd0, BASE, sess_words[0]});
    do_start(8'd3);
    send_word(sess_words[0], 0);
    check("abort_first_write", {63'b0, mem_we}, 64'd1);
    send_byte(8'(sess_words[1] >> 24), 0);
    send_byte(8'(sess_words[1] >> 16), 0);
    rst = 1'b1;
    tick();
    check_reset_outputs("abort");
    rst = 1'b0;
    repeat (3) tick();
    check("abort_stays_idle", {62'b0, busy, done}, 64'd0);

    // Recovery after the abort
    sess_words = '{32'($urandom)};
    run_session(2, 1'b0, 1'b0);

    repeat (5) tick();
    check("writes_drained", 64'(exp_wr.size()), 64'd0);
    check("events_drained", 64'(exp_ev.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
